// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdrHi,
    StHdrLo,
    StData,
    StDone,
    StErr
  } state_e;

  localparam int unsigned HdrBytes     = 2;
  localparam int unsigned BytesPerWord = 4;

endpackage

// File: rtl/word_assembler.sv
// Packs a big-endian byte stream into words; flags the transfer that completes a word.
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      clear_i,
  input  logic                      byte_valid_i,
  input  logic [7:0]                byte_i,
  output logic [8*BytesPerWord-1:0] word_o,
  output logic                      word_done_o
);

  logic [1:0]                      cnt_q;
  logic [8*(BytesPerWord-1)-1:0]   shift_q;

  // The completing byte is taken straight from the input so the word is ready on that edge.
  assign word_o      = {shift_q, byte_i};
  assign word_done_o = byte_valid_i && (cnt_q == 2'(BytesPerWord - 1));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (byte_valid_i) begin
      cnt_q   <= cnt_q + 2'd1;
      shift_q <= {shift_q[8*(BytesPerWord-2)-1:0], byte_i};
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian program stream into instruction memory,
// holding the core in reset until the whole image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter int unsigned MEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam int unsigned CntW = 8 * HdrBytes;

  state_e            state_q, state_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [CntW-1:0]   word_idx_q, word_idx_d;
  logic [CntW-1:0]   hdr_count;
  logic              xfer;
  logic              asm_clear;
  logic              asm_valid;
  logic              word_done;
  logic [31:0]       word;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StHdrHi, StHdrLo, StData: in_ready = 1'b1;
      default:                  in_ready = 1'b0;
    endcase
  end

  assign xfer      = in_valid && in_ready;
  assign asm_valid = xfer && (state_q == StData);
  assign hdr_count = {count_q[CntW-1:8], in_data};

  word_assembler u_word_assembler (
    .clk_i        (clk),
    .rst_i        (rst),
    .clear_i      (asm_clear),
    .byte_valid_i (asm_valid),
    .byte_i       (in_data),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    word_idx_d = word_idx_q;
    asm_clear  = 1'b0;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d    = StHdrHi;
          word_idx_d = '0;
          asm_clear  = 1'b1;
        end
      end
      StHdrHi: begin
        if (xfer) begin
          count_d = {in_data, 8'h00};
          state_d = StHdrLo;
        end
      end
      StHdrLo: begin
        if (xfer) begin
          count_d = hdr_count;
          if (hdr_count == '0) begin
            state_d = StDone;
          end else if (32'(hdr_count) > MEM_DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (word_done) begin
          word_idx_d = word_idx_q + 1'b1;
          if (word_idx_q == count_q - 1'b1) begin
            state_d = StDone;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      count_q    <= '0;
      word_idx_q <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= ADDR_BASE;
      wr_data    <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      word_idx_q <= word_idx_d;
      wr_en      <= asm_valid && word_done;
      if (asm_valid && word_done) begin
        wr_addr <= ADDR_BASE + (32'(word_idx_q) << 2);
        wr_data <= word;
      end
    end
  end

  assign done = (state_q == StDone);
  assign err  = (state_q == StErr);
  // The core stays in reset through the final write, which lands in the first DONE cycle.
  assign cpu_rst = !((state_q == StDone) && !wr_en);

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader against a stream-level reference model.
module tb_imem_loader;

  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
  localparam int unsigned MEM_DEPTH = 256;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_rst;
  logic        done;
  logic        err;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  imem_loader #(
    .ADDR_BASE (ADDR_BASE),
    .MEM_DEPTH (MEM_DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .cpu_rst  (cpu_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Monitor: every write strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (rst === 1'b0 && wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: addr %h data %h with no write expected", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", wr_addr, e.addr);
        check("wr_data", wr_data, e.data);
        check("cpu_rst_during_write", 32'(cpu_rst), 32'd1);
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    in_data  = b;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_timeout: in_ready %0b, expected 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drive_header(input logic [15:0] n, input int maxgap);
    drive_byte(n[15:8], $urandom_range(maxgap, 0));
    drive_byte(n[7:0], $urandom_range(maxgap, 0));
  endtask

  // Reference model: word k lands at ADDR_BASE + 4k with its bytes sent MSB first.
  task automatic load(input logic [31:0] words[$], input int maxgap, input bit mid_start);
    logic [15:0] n;
    n = 16'(words.size());
    for (int k = 0; k < words.size(); k++)
      exp_q.push_back('{addr: ADDR_BASE + 32'(k) * 32'd4, data: words[k]});
    drive_header(n, maxgap);
    for (int k = 0; k < words.size(); k++) begin
      logic [31:0] w;
      w = words[k];
      for (int j = 3; j >= 0; j--) begin
        drive_byte(w[8*j +: 8], $urandom_range(maxgap, 0));
        if (mid_start && k == 0 && j == 2) pulse_start();
      end
    end
  endtask

  task automatic wait_status(input string tag, input bit exp_err);
    int t;
    t = 0;
    @(negedge clk);
    while (!(done || err) && t < 40) begin @(negedge clk); t++; end
    check({tag, "_done"}, 32'(done), 32'(!exp_err));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(negedge clk);
    check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(exp_err));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w[$];
    rst = 1'b1; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, ADDR_BASE);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // IDLE ignores bytes.
    in_valid = 1'b1; in_data = 8'h5A;
    repeat (3) begin @(posedge clk); #1; end
    check("idle_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b0;

    // Two-word directed image.
    pulse_start();
    w = '{32'h2408_0005, 32'h0800_0000};
    load(w, 0, 1'b0);
    wait_status("two_word", 1'b0);

    // Restart from DONE: core goes back into reset right away.
    pulse_start();
    check("restart_cpu_rst", 32'(cpu_rst), 32'd1);
    check("restart_done", 32'(done), 32'd0);
    w = '{32'h1122_3344};
    load(w, 0, 1'b0);
    wait_status("restart", 1'b0);

    // Empty image.
    pulse_start();
    drive_header(16'h0000, 0);
    @(negedge clk);
    check("empty_done", 32'(done), 32'd1);
    check("empty_cpu_rst", 32'(cpu_rst), 32'd0);

    // Oversized image.
    pulse_start();
    drive_header(16'h0101, 0);
    @(negedge clk);
    check("ovf_err", 32'(err), 32'd1);
    check("ovf_in_ready", 32'(in_ready), 32'd0);
    check("ovf_cpu_rst", 32'(cpu_rst), 32'd1);
    check("ovf_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    check("ovf_still_err", 32'(err), 32'd1);

    // Stalled bytes: 5-cycle gaps around every byte.
    pulse_start();
    check("err_cleared", 32'(err), 32'd0);
    exp_q.push_back('{addr: ADDR_BASE, data: 32'hAABB_CCDD});
    drive_header(16'h0001, 0);
    drive_byte(8'hAA, 5); drive_byte(8'hBB, 5); drive_byte(8'hCC, 5); drive_byte(8'hDD, 5);
    wait_status("stall", 1'b0);

    // Reset mid-word aborts the session with no write.
    pulse_start();
    drive_header(16'h0001, 0);
    drive_byte(8'h12, 0); drive_byte(8'h34, 0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_wr_en", 32'(wr_en), 32'd0);
    check("abort_cpu_rst", 32'(cpu_rst), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    pulse_start();
    w = '{32'($urandom)};
    load(w, 1, 1'b0);
    wait_status("after_abort", 1'b0);

    // Randomized images, one with a start pulse mid-DATA that must be ignored.
    for (int it = 0; it < 6; it++) begin
      int n;
      pulse_start();
      n = $urandom_range(8, 1);
      w = {};
      for (int k = 0; k < n; k++) w.push_back($urandom);
      load(w, 3, it == 2);
      wait_status("random", 1'b0);
    end

    // Full-capacity image.
    pulse_start();
    w = {};
    for (int k = 0; k < int'(MEM_DEPTH); k++) w.push_back($urandom);
    load(w, 0, 1'b0);
    wait_status("full", 1'b0);

    repeat (5) @(negedge clk);
    check("final_pending_writes", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_BASE, default 32'h0000_0000: byte address of the first instruction word written.
REQ-002 Parameter MEM_DEPTH, default 256: instruction memory capacity in 32-bit words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 start  input  1  one-cycle pulse that begins a load session.
REQ-006 in_data  input  8  program byte stream.
REQ-007 in_valid  input  1  in_data holds a valid byte.
REQ-008 in_ready  output  1  loader accepts a byte; transfer occurs when in_valid and in_ready are both high on a rising edge.
REQ-009 wr_en  output  1  one-cycle instruction-memory write strobe.
REQ-010 wr_addr  output  32  byte address of the write; word-aligned.
REQ-011 wr_data  output  32  instruction word to write.
REQ-012 cpu_rst  output  1  holds the processor core in reset while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 err  output  1  header word count exceeded MEM_DEPTH.

Function
REQ-015 The FSM SHALL have states IDLE, HDR_HI, HDR_LO, DATA, DONE and ERR.
REQ-016 The stream format SHALL be a 16-bit word count N (MSB byte first), then N words of 4 bytes each, MSB byte first (big-endian).
REQ-017 IDLE -> HDR_HI on start; all other inputs are ignored in IDLE.
REQ-018 HDR_HI captures count[15:8] on transfer -> HDR_LO; HDR_LO captures count[7:0] on transfer.
REQ-019 From HDR_LO: N = 0 -> DONE; N > MEM_DEPTH -> ERR; otherwise -> DATA.
REQ-020 in_ready SHALL be high only in HDR_HI, HDR_LO and DATA, and SHALL be combinational from the state alone.
REQ-021 In DATA, a 2-bit byte counter shifts bytes into the word; the 4th transfer completes the word.
REQ-022 wr_en SHALL pulse high for exactly one cycle, the cycle after the 4th byte transfer, with wr_addr and wr_data stable in that cycle.
REQ-023 The k-th word (k from 0) SHALL be written at wr_addr = ADDR_BASE + 4*k; the address is 32-bit wrapping arithmetic.
REQ-024 The 4th-byte transfer of word N-1 SHALL move the FSM to DONE; the final wr_en pulse occurs in the first DONE cycle.
REQ-025 in_valid low stalls the FSM without losing partial-word bytes; gaps of any length are legal.
REQ-026 cpu_rst SHALL be high in every state except DONE, and SHALL go low in the cycle after the final wr_en pulse.
REQ-027 done SHALL be high only in DONE; err SHALL be high only in ERR.
REQ-028 start in DONE or ERR SHALL return to HDR_HI, clear done/err, reassert cpu_rst and reset the word index to 0.
REQ-029 start in HDR_HI, HDR_LO or DATA SHALL be ignored.
REQ-030 In ERR, no bytes are accepted and no writes are issued.

Reset
REQ-031 On rst: state IDLE, in_ready 0, wr_en 0, wr_addr ADDR_BASE, wr_data 0, cpu_rst 1, done 0, err 0, byte counter 0, word index 0.
REQ-032 rst asserted mid-load SHALL abort the session immediately, discard any partial word and suppress a pending wr_en.

Structure
REQ-033 A shared package SHALL hold the state enumeration, the header length (2 bytes), and the bytes-per-word constant (4).
REQ-034 Byte-to-word shifting and the byte counter SHALL live in one sub-module, word_assembler, with a word_done pulse output.

Verification
REQ-035 Stream 00 02 | 24 08 00 05 | 08 00 00 00 after start -> writes 0x24080005 @0x0 and 0x08000000 @0x4; then done=1, cpu_rst=0.
REQ-036 Header 00 00 -> no wr_en; done=1 and cpu_rst=0 in the cycle after the HDR_LO transfer.
REQ-037 Header 01 01 (257) with MEM_DEPTH=256 -> err=1, in_ready=0, no writes, cpu_rst=1.
REQ-038 Header 00 01, then word AA BB CC DD with in_valid low for 5 cycles between bytes -> single write 0xAABBCCDD @ADDR_BASE.
REQ-039 rst pulse after 2 bytes of a word -> IDLE, no write; next start plus a 1-word stream writes @ADDR_BASE.
REQ-040 start in DONE, then header 00 01 and word 11 22 33 44 -> cpu_rst rises immediately; write 0x11223344 @ADDR_BASE; done re-asserts.
